// File: rtl/dot_collector.sv
// Per-frame pellet collision scanner: walks the pellet table once per frame,
// raising sticky kill bits, accumulating a saturating score and a level-clear flag.
module dot_collector #(
  parameter int N_DOTS     = 16,
  parameter int HIT_RADIUS = 8,
  parameter int POINTS     = 10,
  parameter int SCORE_W    = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_start,
  input  logic [9:0]            PlayerX,
  input  logic [9:0]            PlayerY,
  input  logic [10*N_DOTS-1:0]  dot_x,
  input  logic [10*N_DOTS-1:0]  dot_y,
  input  logic [N_DOTS-1:0]     dot_alive,
  output logic [N_DOTS-1:0]     kill,
  output logic [SCORE_W-1:0]    score,
  output logic                  eat_pulse,
  output logic                  busy,
  output logic                  level_clear
);

  localparam int IDX_W = (N_DOTS > 1) ? $clog2(N_DOTS) : 1;
  localparam int SUM_W = SCORE_W + 32;
  localparam logic [21:0]      R2        = 22'(HIT_RADIUS * HIT_RADIUS);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_DOTS - 1);
  localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'({SCORE_W{1'b1}});

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_SCAN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [9:0]           px_q, px_d, py_q, py_d;
  logic [N_DOTS-1:0]    kill_q, kill_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 eat_q, eat_d;
  logic                 busy_q, busy_d;
  logic                 clear_q, clear_d;

  logic [9:0]           cur_x, cur_y;
  logic signed [10:0]   dx, dy;
  logic signed [21:0]   dx_w, dy_w;
  logic [21:0]          dist2;
  logic                 hit;
  logic [SUM_W-1:0]     score_sum;
  logic [SCORE_W-1:0]   score_sat;

  assign cur_x = dot_x[idx_q*10 +: 10];
  assign cur_y = dot_y[idx_q*10 +: 10];
  assign dx    = $signed({1'b0, cur_x}) - $signed({1'b0, px_q});
  assign dy    = $signed({1'b0, cur_y}) - $signed({1'b0, py_q});
  assign dx_w  = 22'(dx);
  assign dy_w  = 22'(dy);
  // |d| <= 1023, so dx^2 + dy^2 < 2^21 and the 22-bit sum never wraps
  assign dist2 = $unsigned(dx_w * dx_w) + $unsigned(dy_w * dy_w);
  assign hit   = dot_alive[idx_q] && !kill_q[idx_q] && (dist2 <= R2);

  assign score_sum = SUM_W'(score_q) + SUM_W'(POINTS);
  assign score_sat = (score_sum > SCORE_MAX) ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    px_d    = px_q;
    py_d    = py_q;
    kill_d  = kill_q;
    score_d = score_q;
    eat_d   = 1'b0;
    clear_d = clear_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) state_d = S_LATCH;
      end
      S_LATCH: begin
        px_d    = PlayerX;
        py_d    = PlayerY;
        idx_d   = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (hit) begin
          kill_d[idx_q] = 1'b1;
          score_d       = score_sat;
          eat_d         = 1'b1;
        end
        if (idx_q == LAST_IDX) state_d = S_DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      S_DONE: begin
        if ((dot_alive & ~kill_q) == '0) clear_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      kill_q  <= '0;
      score_q <= '0;
      eat_q   <= 1'b0;
      busy_q  <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      px_q    <= px_d;
      py_q    <= py_d;
      kill_q  <= kill_d;
      score_q <= score_d;
      eat_q   <= eat_d;
      busy_q  <= busy_d;
      clear_q <= clear_d;
    end
  end

  assign kill        = kill_q;
  assign score       = score_q;
  assign eat_pulse   = eat_q;
  assign busy        = busy_q;
  assign level_clear = clear_q;

endmodule

// File: tb/tb_dot_collector.sv
// Directed bench for dot_collector: table of single-frame scans plus
// hand-written timing, stickiness, busy, saturation and mid-scan reset sequences.
module tb_dot_collector;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         frame_start;
  logic [9:0]   player_x, player_y;
  logic [159:0] dot_x, dot_y;
  logic [15:0]  dot_alive;
  logic [15:0]  kill;
  logic [15:0]  score;
  logic         eat_pulse, busy, level_clear;

  logic         b_frame;
  logic [39:0]  b_dx, b_dy;
  logic [3:0]   b_alive, b_kill;
  logic [4:0]   b_score;
  logic         b_eat, b_busy, b_clear;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dot_collector dut (
    .Clk(clk), .Reset(rst_n), .frame_start(frame_start),
    .PlayerX(player_x), .PlayerY(player_y),
    .dot_x(dot_x), .dot_y(dot_y), .dot_alive(dot_alive),
    .kill(kill), .score(score), .eat_pulse(eat_pulse),
    .busy(busy), .level_clear(level_clear)
  );

  dot_collector #(.N_DOTS(4), .HIT_RADIUS(8), .POINTS(10), .SCORE_W(5)) dut_b (
    .Clk(clk), .Reset(rst_n), .frame_start(b_frame),
    .PlayerX(player_x), .PlayerY(player_y),
    .dot_x(b_dx), .dot_y(b_dy), .dot_alive(b_alive),
    .kill(b_kill), .score(b_score), .eat_pulse(b_eat),
    .busy(b_busy), .level_clear(b_clear)
  );

  typedef struct {
    logic [9:0]  px;
    logic [9:0]  py;
    logic [39:0] xs;
    logic [39:0] ys;
    logic [3:0]  alive;
    logic [3:0]  exp_kill;
    int          exp_score;
    int          exp_pulses;
    logic        exp_clear;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_vec(input vec_t v);
    player_x  = v.px;
    player_y  = v.py;
    dot_x     = {{12{10'd1000}}, v.xs};
    dot_y     = {{12{10'd1000}}, v.ys};
    dot_alive = {12'h000, v.alive};
  endtask

  // cycle 0 is the cycle in which frame_start is high; cycle c is sampled at its negedge
  task automatic run_scan(input int extra_fs, output int n_pulse, output int first_p,
                          output int last_p, output int idle_c, output logic busy_end);
    n_pulse = 0; first_p = -1; last_p = -1; idle_c = -1; busy_end = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (eat_pulse) begin
        n_pulse++;
        if (first_p < 0) first_p = c;
        last_p = c;
      end
      if (!busy && idle_c < 0) idle_c = c;
      busy_end = busy;
      frame_start = (c == extra_fs);
    end
    frame_start = 1'b0;
  endtask

  int   np, fp, lp, ic;
  logic be;

  initial begin
    // px, py, {x3,x2,x1,x0}, {y3,y2,y1,y0}, alive, kill, score, pulses, clear
    vecs[0] = '{10'd100, 10'd100, {10'd500, 10'd106, 10'd108, 10'd100},
                {10'd500, 10'd106, 10'd100, 10'd100}, 4'b0111, 4'b0011, 20, 2, 1'b0};
    vecs[1] = '{10'd100, 10'd100, {10'd100, 10'd105, 10'd100, 10'd92},
                {10'd100, 10'd105, 10'd92, 10'd100}, 4'b0111, 4'b0111, 30, 3, 1'b1};
    vecs[2] = '{10'd0, 10'd0, {10'd6, 10'd5, 10'd0, 10'd8},
                {10'd6, 10'd6, 10'd9, 10'd0}, 4'b1111, 4'b0101, 20, 2, 1'b0};
    vecs[3] = '{10'd1023, 10'd1023, {10'd1019, 10'd1017, 10'd0, 10'd1023},
                {10'd1019, 10'd1017, 10'd0, 10'd1015}, 4'b1111, 4'b1001, 20, 2, 1'b0};
    vecs[4] = '{10'd10, 10'd500, {10'd17, 10'd10, 10'd1, 10'd2},
                {10'd495, 10'd507, 10'd500, 10'd500}, 4'b1111, 4'b0101, 20, 2, 1'b0};

    frame_start = 1'b0; b_frame = 1'b0;
    player_x = '0; player_y = '0;
    dot_x = '0; dot_y = '0; dot_alive = '0;
    b_dx = '0; b_dy = '0; b_alive = '0;

    do_reset();
    check("rst kill", 32'(kill), 0);
    check("rst score", 32'(score), 0);
    check("rst busy", 32'(busy), 0);
    check("rst clear", 32'(level_clear), 0);
    check("rst eat", 32'(eat_pulse), 0);
    check("rst b_score", 32'(b_score), 0);

    for (int i = 0; i < 5; i++) begin
      do_reset();
      load_vec(vecs[i]);
      run_scan(-1, np, fp, lp, ic, be);
      check($sformatf("v%0d kill", i), 32'(kill), 32'({12'h000, vecs[i].exp_kill}));
      check($sformatf("v%0d score", i), 32'(score), 32'(vecs[i].exp_score));
      check($sformatf("v%0d pulses", i), 32'(np), 32'(vecs[i].exp_pulses));
      check($sformatf("v%0d clear", i), 32'(level_clear), 32'(vecs[i].exp_clear));
    end

    // timing of strobes and busy, then stickiness on a second frame
    do_reset();
    load_vec(vecs[0]);
    run_scan(-1, np, fp, lp, ic, be);
    check("t first pulse", 32'(fp), 3);
    check("t last pulse", 32'(lp), 4);
    check("t idle cycle", 32'(ic), 19);
    run_scan(-1, np, fp, lp, ic, be);
    check("sticky score", 32'(score), 20);
    check("sticky pulses", 32'(np), 0);
    check("sticky kill", 32'(kill), 32'h0003);

    // frame_start while busy is dropped
    do_reset();
    load_vec(vecs[0]);
    run_scan(5, np, fp, lp, ic, be);
    check("busy fs score", 32'(score), 20);
    check("busy fs idle", 32'(ic), 19);
    check("busy fs end", 32'(be), 0);

    // frame_start on the DONE->IDLE edge is dropped
    do_reset();
    load_vec(vecs[0]);
    run_scan(18, np, fp, lp, ic, be);
    check("done fs idle", 32'(ic), 19);
    check("done fs end", 32'(be), 0);

    // reset mid-scan, then a clean rescan
    do_reset();
    load_vec(vecs[0]);
    @(negedge clk);
    frame_start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      frame_start = 1'b0;
      if (c == 3) begin
        check("mid eat", 32'(eat_pulse), 1);
        check("mid kill", 32'(kill), 32'h0001);
      end
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("mid rst kill", 32'(kill), 0);
    check("mid rst score", 32'(score), 0);
    check("mid rst busy", 32'(busy), 0);
    rst_n = 1'b1;
    run_scan(-1, np, fp, lp, ic, be);
    check("rescan kill", 32'(kill), 32'h0003);
    check("rescan score", 32'(score), 20);

    // saturation and level clear on the 4-pellet, 5-bit-score instance
    do_reset();
    player_x = 10'd200; player_y = 10'd300;
    b_dx = {4{10'd200}}; b_dy = {4{10'd300}}; b_alive = 4'hF;
    @(negedge clk);
    b_frame = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      b_frame = 1'b0;
      if (c == 5) check("b score 3 hits", 32'(b_score), 30);
      if (c == 6) begin
        check("b score sat", 32'(b_score), 31);
        check("b clear in done", 32'(b_clear), 0);
      end
      if (c == 7) begin
        check("b clear after done", 32'(b_clear), 1);
        check("b busy idle", 32'(b_busy), 0);
      end
    end
    check("b kill", 32'(b_kill), 32'hF);
    @(negedge clk);
    b_frame = 1'b1;
    @(negedge clk);
    b_frame = 1'b0;
    repeat (10) @(negedge clk);
    check("b clear sticky", 32'(b_clear), 1);
    check("b score sticky", 32'(b_score), 31);
    do_reset();
    check("b clear rst", 32'(b_clear), 0);
    check("b score rst", 32'(b_score), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
